// File: rtl/alu_logic_pkg.sv
// Shared encodings for the multicycle bitwise logic unit: op codes, FSM states
// and a helper for sizing the chunk counter.
package alu_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // A single-chunk unit still needs a 1-bit counter so the select stays legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitwise_logic_slice.sv
// CHUNK-wide combinational AND/OR/XOR/NOR cell; zero latency, no handshake.
module bitwise_logic_slice
  import alu_logic_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [1:0]       op,
  output logic [CHUNK-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_engine.sv
// Multicycle bitwise op on WIDTH-bit operands, CHUNK bits per cycle, LSB first.
// Result after WIDTH/CHUNK RUN cycles with a one-cycle RDY pulse; a start in any state restarts.
module bitwise_logic_engine
  import alu_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [1:0]       ctrl_op,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_resultRDY,
  output logic             data_busy,
  output logic             data_zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("bitwise_logic_engine: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] y_chunk;
  logic [WIDTH-1:0] work_upd;

  // The one slice is time-shared across chunks via the counter-driven select.
  assign base    = 32'(cnt_q) * 32'(CHUNK);
  assign a_chunk = a_q[base +: CHUNK];
  assign b_chunk = b_q[base +: CHUNK];

  bitwise_logic_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a  (a_chunk),
    .b  (b_chunk),
    .op (op_q),
    .y  (y_chunk)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    res_d    = res_q;
    zero_d   = zero_q;
    work_upd = work_q;
    work_upd[base +: CHUNK] = y_chunk;

    if (ctrl_start) begin
      // Accepted in every state; an in-flight operation is dropped without a pulse.
      state_d = ST_RUN;
      cnt_d   = '0;
      op_d    = ctrl_op;
      a_d     = data_operandA;
      b_d     = data_operandB;
      work_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          work_d = work_upd;
          if (cnt_q == CNT_LAST) begin
            res_d   = work_upd;
            zero_d  = (work_upd == '0);
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data_busy      = (state_q == ST_RUN);
    data_resultRDY = (state_q == ST_DONE);
    data_result    = res_q;
    data_zero      = zero_q;
  end

endmodule

// File: tb/tb_bitwise_logic_engine.sv
// Bench for two engine instances: index 0 is WIDTH=32/CHUNK=8, index 1 is WIDTH=32/CHUNK=32.
module tb_bitwise_logic_engine;

  logic        clk;
  logic        rst;
  logic        st    [2];
  logic [1:0]  opv   [2];
  logic [31:0] av    [2];
  logic [31:0] bv    [2];
  logic [31:0] res_o [2];
  logic        rdy_o [2];
  logic        busy_o[2];
  logic        zero_o[2];

  int          n_vec;
  int          n_fail;
  logic        chk_en;
  logic [31:0] exp_v;

  // Model: cycles left until completion, pending value, last result, RDY flag.
  int          m_left[2];
  logic [31:0] m_pend[2];
  logic [31:0] m_res [2];
  logic        m_rdy [2];

  bitwise_logic_engine #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clock          (clk),
    .reset          (rst),
    .ctrl_start     (st[0]),
    .ctrl_op        (opv[0]),
    .data_operandA  (av[0]),
    .data_operandB  (bv[0]),
    .data_result    (res_o[0]),
    .data_resultRDY (rdy_o[0]),
    .data_busy      (busy_o[0]),
    .data_zero      (zero_o[0])
  );

  bitwise_logic_engine #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clock          (clk),
    .reset          (rst),
    .ctrl_start     (st[1]),
    .ctrl_op        (opv[1]),
    .data_operandA  (av[1]),
    .data_operandB  (bv[1]),
    .data_result    (res_o[1]),
    .data_resultRDY (rdy_o[1]),
    .data_busy      (busy_o[1]),
    .data_zero      (zero_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_left[k] <= 0;
        m_pend[k] <= '0;
        m_res[k]  <= '0;
        m_rdy[k]  <= 1'b0;
      end else begin
        m_rdy[k] <= 1'b0;
        if (st[k]) begin
          m_pend[k] <= ref_op(opv[k], av[k], bv[k]);
          m_left[k] <= (k == 0) ? 4 : 1;
        end else if (m_left[k] == 1) begin
          m_left[k] <= 0;
          m_res[k]  <= m_pend[k];
          m_rdy[k]  <= 1'b1;
        end else if (m_left[k] > 1) begin
          m_left[k] <= m_left[k] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_left[k] != 0));
        check($sformatf("rdy%0d", k),  32'(rdy_o[k]),  32'(m_rdy[k]));
        check($sformatf("res%0d", k),  res_o[k],       m_res[k]);
        check($sformatf("zero%0d", k), 32'(zero_o[k]), 32'(m_res[k] == 32'h0));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic start0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    opv[0] = op;
    av[0]  = a;
    bv[0]  = b;
    st[0]  = 1'b1;
    tick();
    st[0] = 1'b0;
    av[0] = $urandom;
    bv[0] = $urandom;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec  = 0;
    n_fail = 0;
    chk_en = 1'b0;
    rst    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      st[k]  = 1'b0;
      opv[k] = 2'b00;
      av[k]  = '0;
      bv[k]  = '0;
    end
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_res",  res_o[0],         32'h0);
    check("rst_zero", 32'(zero_o[0]),   32'h1);
    check("rst_busy", 32'(busy_o[0]),   32'h0);
    check("rst_rdy",  32'(rdy_o[0]),    32'h0);
    rst = 1'b0;
    tick();

    // OR, 4-cycle latency
    start0(2'b01, 32'hF0F00000, 32'h0F0F1234);
    for (int i = 0; i < 3; i++) begin
      check("or_busy", 32'(busy_o[0]), 32'h1);
      check("or_early_rdy", 32'(rdy_o[0]), 32'h0);
      tick();
    end
    tick();
    check("or_rdy", 32'(rdy_o[0]), 32'h1);
    check("or_res", res_o[0], 32'hFFFF1234);
    check("or_zero", 32'(zero_o[0]), 32'h0);
    check("model_or", m_res[0], 32'hFFFF1234);
    tick();
    check("or_rdy_once", 32'(rdy_o[0]), 32'h0);

    // XOR to zero, then NOR of zeros
    start0(2'b10, 32'hDEADBEEF, 32'hDEADBEEF);
    check("xor_hold", res_o[0], 32'hFFFF1234);
    for (int i = 0; i < 4; i++) tick();
    check("xor_res", res_o[0], 32'h0);
    check("xor_zero", 32'(zero_o[0]), 32'h1);
    tick();
    start0(2'b11, 32'h0, 32'h0);
    check("nor_hold", res_o[0], 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("nor_res", res_o[0], 32'hFFFFFFFF);
    check("nor_zero", 32'(zero_o[0]), 32'h0);
    check("model_nor", m_res[0], 32'hFFFFFFFF);

    // Start while in DONE, then restart two cycles later
    check("done_rdy", 32'(rdy_o[0]), 32'h1);
    start0(2'b00, 32'hFFFFFFFF, 32'h12345678);
    tick();
    start0(2'b01, 32'h00000000, 32'h00000001);
    check("restart_hold", res_o[0], 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      check("restart_no_rdy", 32'(rdy_o[0]), 32'h0);
      tick();
    end
    tick();
    check("restart_rdy", 32'(rdy_o[0]), 32'h1);
    check("restart_res", res_o[0], 32'h00000001);
    tick();

    // Reset mid-RUN
    start0(2'b10, $urandom, $urandom);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy_o[0]), 32'h0);
    check("midrst_res", res_o[0], 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_rdy", 32'(rdy_o[0]), 32'h0);
      tick();
    end

    // Single-cycle instance
    opv[1] = 2'b00;
    av[1]  = 32'hFF00FF00;
    bv[1]  = 32'h0FF00FF0;
    st[1]  = 1'b1;
    tick();
    st[1] = 1'b0;
    check("n1_busy", 32'(busy_o[1]), 32'h1);
    tick();
    check("n1_rdy", 32'(rdy_o[1]), 32'h1);
    check("n1_res", res_o[1], 32'h0F000F00);
    for (int i = 0; i < 4; i++) begin
      opv[1] = 2'($urandom_range(0, 3));
      av[1]  = $urandom;
      bv[1]  = $urandom;
      exp_v  = ref_op(opv[1], av[1], bv[1]);
      st[1]  = 1'b1;
      tick();
      st[1] = 1'b0;
      av[1] = $urandom;
      tick();
      check("n1_b2b_rdy", 32'(rdy_o[1]), 32'h1);
      check("n1_b2b_res", res_o[1], exp_v);
    end

    // Random traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 2; k++) begin
        st[k]  = ($urandom_range(0, 4) == 0);
        opv[k] = 2'($urandom_range(0, 3));
        av[k]  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        bv[k]  = ($urandom_range(0, 7) == 0) ? av[k] : $urandom;
      end
      tick();
    end
    rst = 1'b0;
    st[0] = 1'b0;
    st[1] = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
